icache_fill: RTL and testbench

//  Line-fill engine between the I-cache miss logic and the main bus. Takes one miss request and issues
//  a read command on bmain. Collects the 4-beat burst returned by the boot ROM or another bmain slave.

---
 rtl/icache_fill.sv | 193 +++++++++++++++++++
 tb/tb_icache_fill.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// icache_fill: I-cache line-fill engine.
//   Accepts one miss request, issues a read command on bmain, collects a
//   LINE_WORDS-beat burst and writes each beat into the cache data array.
//   It then reports completion, with an error qualifier, back to the cache.
//
// Ports
//   i_clk_core, i_reset        core clock, synchronous active-high reset
//   i_req_valid/o_req_ready    miss request handshake
//   i_req_addr                 line address [AW-1:4]
//   i_req_word                 critical-word offset (forwarding build only)
//   o_fill_cvalid/i_bmain_cready, o_fill_cmd, o_fill_addr   bus read command
//   i_bmain_rvalid/o_fill_rready, i_bmain_rlast, i_bmain_rdata  read beats
//   i_bmain_error/o_fill_eack  slave error and its acknowledge
//   o_fill_we, o_fill_windex, o_fill_wdata   cache-array write port
//   o_fill_done, o_fill_err    completion pulse and line-invalid qualifier
//   o_fwd_valid, o_fwd_data    critical-word forward
//
// Build option
//   ICACHE_FILL_FWD_EN : forward the requested word as soon as it is written.
//                        When undefined, fwd outputs are tied to 0.
module icache_fill #(
  parameter int LINE_WORDS = 4,
  parameter int AW         = 32,
  localparam int IW        = $clog2(LINE_WORDS)
) (
  input  logic            i_clk_core,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [AW-5:0]   i_req_addr,
  input  logic [IW-1:0]   i_req_word,
  output logic            o_fill_cvalid,
  input  logic            i_bmain_cready,
  output logic            o_fill_cmd,
  output logic [AW-3:0]   o_fill_addr,
  input  logic            i_bmain_rvalid,
  output logic            o_fill_rready,
  input  logic            i_bmain_rlast,
  input  logic [31:0]     i_bmain_rdata,
  input  logic            i_bmain_error,
  output logic            o_fill_eack,
  output logic            o_fill_we,
  output logic [IW-1:0]   o_fill_windex,
  output logic [31:0]     o_fill_wdata,
  output logic            o_fill_done,
  output logic            o_fill_err,
  output logic            o_fwd_valid,
  output logic [31:0]     o_fwd_data
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_ERR, S_DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

  state_t          r_state;
  logic            r_req_ready, r_cvalid, r_rready, r_eack;
  logic            r_we, r_done, r_ferr, r_err;
  logic [AW-5:0]   r_line;
  logic [IW-1:0]   r_cnt, r_windex;
  logic [31:0]     r_wdata;

  logic w_beat, w_proto_err;
  assign w_beat      = i_bmain_rvalid & r_rready;
  // rlast must coincide exactly with the final beat index; an early rlast or
  // a final-index beat without rlast both mark the line bad.
  assign w_proto_err = i_bmain_rlast ^ (r_cnt == LAST);

`ifdef ICACHE_FILL_FWD_EN
  logic [IW-1:0] r_word;
  logic          r_fwd_valid;
  logic [31:0]   r_fwd_data;
`else
  logic w_unused;
  assign w_unused = ^i_req_word;
`endif

  always_ff @(posedge i_clk_core) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_cvalid    <= 1'b0;
      r_rready    <= 1'b0;
      r_eack      <= 1'b0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_ferr      <= 1'b0;
      r_err       <= 1'b0;
      r_line      <= '0;
      r_cnt       <= '0;
      r_windex    <= '0;
      r_wdata     <= '0;
`ifdef ICACHE_FILL_FWD_EN
      r_word      <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
`endif
    end else begin
      // single-cycle strobes
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_eack <= 1'b0;
`ifdef ICACHE_FILL_FWD_EN
      r_fwd_valid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_line      <= i_req_addr;
`ifdef ICACHE_FILL_FWD_EN
            r_word      <= i_req_word;
`endif
            r_req_ready <= 1'b0;
            r_cvalid    <= 1'b1;
            r_state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (i_bmain_error) begin
            r_cvalid <= 1'b0;
            r_rready <= 1'b1;
            r_eack   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= S_ERR;
          end else if (i_bmain_cready) begin
            r_cvalid <= 1'b0;
            r_cnt    <= '0;
            r_rready <= 1'b1;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          // error beats the same-cycle data beat; that beat is dropped
          if (i_bmain_error) begin
            r_eack  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else if (w_beat) begin
            r_we     <= 1'b1;
            r_windex <= r_cnt;
            r_wdata  <= i_bmain_rdata;
            r_cnt    <= r_cnt + 1'b1;
            if (w_proto_err) r_err <= 1'b1;
`ifdef ICACHE_FILL_FWD_EN
            if (r_cnt == r_word && !r_err) begin
              r_fwd_valid <= 1'b1;
              r_fwd_data  <= i_bmain_rdata;
            end
`endif
            if (i_bmain_rlast) begin
              r_rready <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        S_ERR: begin
          // rready stays high here so stray beats are drained, not written
          r_rready <= 1'b0;
          r_err    <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_ferr  <= r_err;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_fill_cvalid = r_cvalid;
  assign o_fill_cmd    = 1'b0;
  assign o_fill_addr   = {r_line, {IW{1'b0}}};
  assign o_fill_rready = r_rready;
  assign o_fill_eack   = r_eack;
  assign o_fill_we     = r_we;
  assign o_fill_windex = r_windex;
  assign o_fill_wdata  = r_wdata;
  assign o_fill_done   = r_done;
  assign o_fill_err    = r_ferr;
`ifdef ICACHE_FILL_FWD_EN
  assign o_fwd_valid   = r_fwd_valid;
  assign o_fwd_data    = r_fwd_data;
`else
  assign o_fwd_valid   = 1'b0;
  assign o_fwd_data    = '0;
`endif

endmodule

// File: tb/tb_icache_fill.sv
module tb_icache_fill;
  localparam int AW = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [27:0] req_addr = '0;
  logic [1:0]  req_word = '0;
  logic        cvalid, cready = 1'b0, cmd;
  logic [29:0] faddr;
  logic        rvalid = 1'b0, rready, rlast = 1'b0, berr = 1'b0, eack;
  logic [31:0] rdata = '0;
  logic        we, done, ferr, fwd_valid;
  logic [1:0]  windex;
  logic [31:0] wdata, fwd_data;

  icache_fill #(.LINE_WORDS(4), .AW(AW)) dut (
    .i_clk_core(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_word(req_word),
    .o_fill_cvalid(cvalid), .i_bmain_cready(cready), .o_fill_cmd(cmd),
    .o_fill_addr(faddr),
    .i_bmain_rvalid(rvalid), .o_fill_rready(rready), .i_bmain_rlast(rlast),
    .i_bmain_rdata(rdata), .i_bmain_error(berr), .o_fill_eack(eack),
    .o_fill_we(we), .o_fill_windex(windex), .o_fill_wdata(wdata),
    .o_fill_done(done), .o_fill_err(ferr),
    .o_fwd_valid(fwd_valid), .o_fwd_data(fwd_data)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---- monitor: log strobes on the falling edge ----
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          we_n, done_n, eack_n, fwd_n, fwd_tot = 0;
  logic [1:0]  we_idx [16];
  logic [31:0] we_dat [16];
  int          we_cyc [16];
  int          done_cyc, fwd_cyc;
  logic        done_err, done_rr;
  logic [31:0] fwd_dat;

  always @(negedge clk) begin
    if (we && we_n < 16) begin
      we_idx[we_n] = windex; we_dat[we_n] = wdata; we_cyc[we_n] = cyc; we_n++;
    end
    if (done) begin
      done_n++; done_cyc = cyc; done_err = ferr; done_rr = req_ready;
    end
    if (eack) eack_n++;
    if (fwd_valid) begin
      fwd_n++; fwd_tot++; fwd_dat = fwd_data; fwd_cyc = cyc;
    end
  end

  task automatic clear_log();
    we_n = 0; done_n = 0; eack_n = 0; fwd_n = 0;
    done_cyc = 0; fwd_cyc = -1; done_err = 1'b0; done_rr = 1'b1; fwd_dat = '0;
  endtask

  task automatic issue_req(input logic [27:0] a, input logic [1:0] w);
    int k = 0;
    while (!req_ready && k < 20) begin step(); k++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_word = w;
    step();
    req_valid = 1'b0;
  endtask

  // command phase: cready withheld for 'stall' cycles, command must hold
  task automatic cmd_phase(input int stall, input logic [29:0] exp_addr);
    for (int i = 0; i <= stall; i++) begin
      chk("cmd_cvalid", 32'(cvalid), 32'd1);
      chk("cmd_addr", 32'(faddr), 32'(exp_addr));
      chk("cmd_no_rready", 32'(rready), 32'd0);
      if (i == stall) cready = 1'b1;
      step();
    end
    cready = 1'b0;
    chk("data_rready", 32'(rready), 32'd1);
    chk("data_cvalid_low", 32'(cvalid), 32'd0);
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input int gap);
    repeat (gap) step();
    rvalid = 1'b1; rdata = d; rlast = l;
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wait_done();
    int prev = done_n;
    int k = 0;
    while (done_n == prev && k < 40) begin step(); k++; end
    chk("done_seen", 32'(done_n), 32'(prev + 1));
  endtask

  task automatic chk_writes(input int n, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] exp_d [4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    chk("we_count", 32'(we_n), 32'(n));
    for (int i = 0; i < n && i < we_n; i++) begin
      chk("we_idx", 32'(we_idx[i]), 32'(i));
      chk("we_data", we_dat[i], exp_d[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_log();
    // reset state
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_cvalid", 32'(cvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_eack", 32'(eack), 32'd0);
    chk("rst_addr", 32'(faddr), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    reset = 1'b0;
    step();

    // 1: basic line, critical word 2
    clear_log();
    issue_req(28'h000_0001, 2'd2);
    cmd_phase(0, 30'h4);
    chk("t1_cmd_read", 32'(cmd), 32'd0);
    beat(32'hA, 1'b0, 0); beat(32'hB, 1'b0, 0);
    beat(32'hC, 1'b0, 0); beat(32'hD, 1'b1, 0);
    wait_done();
    chk_writes(4, 32'hA, 32'hB, 32'hC, 32'hD);
    chk("t1_err", 32'(done_err), 32'd0);
    chk("t1_done_lat", 32'(done_cyc), 32'(we_cyc[3] + 1));
    chk("t1_eack", 32'(eack_n), 32'd0);
    chk("t1_rr_at_done", 32'(done_rr), 32'd0);
    chk("t1_rr_after", 32'(req_ready), 32'd1);
`ifdef ICACHE_FILL_FWD_EN
    chk("t6_fwd_n", 32'(fwd_n), 32'd1);
    chk("t6_fwd_data", fwd_dat, 32'hC);
    chk("t6_fwd_cyc", 32'(fwd_cyc), 32'(we_cyc[2]));
`endif

    // 2: cready stalled 5 cycles
    clear_log();
    issue_req(28'hABC_DEF1, 2'd0);
    cmd_phase(5, {28'hABC_DEF1, 2'b00});
    beat(32'h1111, 1'b0, 0); beat(32'h2222, 1'b0, 0);
    beat(32'h3333, 1'b0, 0); beat(32'h4444, 1'b1, 0);
    wait_done();
    chk_writes(4, 32'h1111, 32'h2222, 32'h3333, 32'h4444);
    chk("t2_err", 32'(done_err), 32'd0);

    // 3: beat every 3rd cycle
    clear_log();
    issue_req(28'h123_4567, 2'd1);
    cmd_phase(0, {28'h123_4567, 2'b00});
    beat(32'hCAFE_0000, 1'b0, 2); beat(32'hCAFE_0001, 1'b0, 2);
    beat(32'hCAFE_0002, 1'b0, 2); beat(32'hCAFE_0003, 1'b1, 2);
    wait_done();
    chk_writes(4, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    chk("t3_done_lat", 32'(done_cyc), 32'(we_cyc[3] + 1));
    chk("t3_err", 32'(done_err), 32'd0);
`ifdef ICACHE_FILL_FWD_EN
    chk("t3_fwd_data", fwd_dat, 32'hCAFE_0001);
`endif

    // 4: slave error after two beats, colliding with a data beat
    clear_log();
    issue_req(28'h000_0010, 2'd3);
    cmd_phase(0, 30'h40);
    beat(32'h5A5A_0000, 1'b0, 0); beat(32'h5A5A_0001, 1'b0, 0);
    berr = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    berr = 1'b0; rvalid = 1'b0;
    chk("t4_eack_now", 32'(eack), 32'd1);
    wait_done();
    chk_writes(2, 32'h5A5A_0000, 32'h5A5A_0001, 32'h0, 32'h0);
    chk("t4_eack_n", 32'(eack_n), 32'd1);
    chk("t4_err", 32'(done_err), 32'd1);
    chk("t4_rr_after", 32'(req_ready), 32'd1);

    // 5a: short burst, rlast on the third beat
    clear_log();
    issue_req(28'h000_0020, 2'd0);
    cmd_phase(0, 30'h80);
    beat(32'h77, 1'b0, 0); beat(32'h88, 1'b0, 0); beat(32'h99, 1'b1, 0);
    wait_done();
    chk_writes(3, 32'h77, 32'h88, 32'h99, 32'h0);
    chk("t5_err", 32'(done_err), 32'd1);
    chk("t5_eack_n", 32'(eack_n), 32'd0);

    // 5b: reset in the middle of DATA
    clear_log();
    issue_req(28'h000_0030, 2'd0);
    cmd_phase(0, 30'hC0);
    beat(32'h42, 1'b0, 0);
    reset = 1'b1;
    step();
    chk("t5r_req_ready", 32'(req_ready), 32'd1);
    chk("t5r_rready", 32'(rready), 32'd0);
    chk("t5r_we", 32'(we), 32'd0);
    chk("t5r_cvalid", 32'(cvalid), 32'd0);
    reset = 1'b0;
    repeat (10) step();
    chk("t5r_no_done", 32'(done_n), 32'd0);
    chk("t5r_idle_ready", 32'(req_ready), 32'd1);

    // recovery: a clean line right after the reset
    clear_log();
    issue_req(28'h000_0040, 2'd3);
    cmd_phase(1, 30'h100);
    beat(32'hE0, 1'b0, 0); beat(32'hE1, 1'b0, 1);
    beat(32'hE2, 1'b0, 0); beat(32'hE3, 1'b1, 0);
    wait_done();
    chk_writes(4, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    chk("rec_err", 32'(done_err), 32'd0);

`ifndef ICACHE_FILL_FWD_EN
    chk("t6_fwd_never", 32'(fwd_tot), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
